// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory access width encodings and
// the data-memory controller FSM state type.
package cpu_pkg;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Data memory word array: synchronous byte-enabled write,
// asynchronous read. Contents are not reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] memory [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    memory[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = memory[idx_i];

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data memory controller with fixed access latency.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module dmem_ctrl
    import cpu_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  width_i,
    input  logic        sign_ext_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        misalign_o
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    dmem_state_e     state_q, state_d;
    logic [3:0]      cnt_q;
    logic            we_q, sext_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [1:0]      width_q;

    logic            fire, mis, accept;
    logic [1:0]      off;
    logic [3:0]      be;
    logic [31:0]     wlane, rword, shifted, ldata;
    logic            unused_addr;

    assign unused_addr = ^addr_i[31:AW+2];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_o = req_i;
                if (req_i) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                stall_o = 1'b1;
                if (cnt_q == 4'd0) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept = (state_q == ST_IDLE) && req_i;
    assign fire   = (state_q == ST_BUSY) && (cnt_q == 4'd0);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis = (width_q == WIDTH_HALF) ? addr_q[0]
               : (width_q != WIDTH_BYTE) && (|addr_q[1:0]);
`else
    assign mis = 1'b0;
`endif

    assign misalign_o = done_o && mis;

    // Lane offset is aligned down to the access width.
    always_comb begin
        off   = 2'b00;
        be    = 4'b1111;
        wlane = wdata_q;
        case (width_q)
            WIDTH_BYTE: begin
                off   = addr_q[1:0];
                be    = 4'b0001 << addr_q[1:0];
                wlane = {4{wdata_q[7:0]}};
            end
            WIDTH_HALF: begin
                off   = {addr_q[1], 1'b0};
                be    = 4'b0011 << {addr_q[1], 1'b0};
                wlane = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = rword >> {off, 3'b000};

    always_comb begin
        ldata = shifted;
        case (width_q)
            WIDTH_BYTE: ldata = {{24{sext_q & shifted[7]}}, shifted[7:0]};
            WIDTH_HALF: ldata = {{16{sext_q & shifted[15]}}, shifted[15:0]};
            default:    ldata = shifted;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            width_q <= 2'b00;
            rdata_o <= 32'd0;
        end else begin
            if (accept) begin
                cnt_q   <= LAT_M1;
                we_q    <= we_i;
                sext_q  <= sign_ext_i;
                addr_q  <= addr_i[AW+1:0];
                wdata_q <= wdata_i;
                width_q <= width_i;
            end else if (state_q == ST_BUSY && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (fire && !we_q) begin
                rdata_o <= mis ? 32'd0 : ldata;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (fire && we_q && !mis),
        .be_i    (be),
        .idx_i   (addr_q[AW+1:2]),
        .wdata_i (wlane),
        .rdata_o (rword)
    );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (DEPTH_WORDS=256,
// LATENCY=2), covering both DMEM_MISALIGN_TRAP_EN builds.
module tb_dmem_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [1:0]  width_i;
    logic        sign_ext_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        done_o;
    logic        misalign_o;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_ctrl #(
        .DEPTH_WORDS (256),
        .LATENCY     (2)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .width_i    (width_i),
        .sign_ext_i (sign_ext_i),
        .rdata_o    (rdata_o),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .misalign_o (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic access(input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] w,
                          input logic se, output int stalls,
                          output logic [31:0] rd, output logic mis,
                          output bit ok);
        stalls = 0;
        ok     = 1'b0;
        rd     = 32'd0;
        mis    = 1'b0;
        @(negedge clk_i);
        req_i      = 1'b1;
        we_i       = we;
        addr_i     = a;
        wdata_i    = wd;
        width_i    = w;
        sign_ext_i = se;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (stall_o) stalls++;
            if (done_o) begin
                ok  = 1'b1;
                rd  = rdata_o;
                mis = misalign_o;
            end
            @(negedge clk_i);
            if (ok) break;
        end
        req_i = 1'b0;
        we_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        req_i = 1'b0;
        #1;
        n_cmp++;
        if (stall_o !== 1'b0 || done_o !== 1'b0 || misalign_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: stall=%b done=%b mis=%b want 0 0 0",
                     stall_o, done_o, misalign_o);
        end
        n_cmp++;
        if (rdata_o !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h want 0", rdata_o);
        end
        req_i = 1'b1;
        #1;
        n_cmp++;
        if (stall_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_stall_follows_req: got %b want 1", stall_o);
        end
        req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_word();
        int st; logic [31:0] rd; logic m; bit ok;
        access(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, st, rd, m, ok);
        n_cmp++;
        if (!ok || st != 3) begin
            n_bad++;
            $display("FAIL word_store_stall: done=%b stalls=%0d want 1 3", ok, st);
        end
        access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, st, rd, m, ok);
        n_cmp++;
        if (!ok || st != 3) begin
            n_bad++;
            $display("FAIL word_load_stall: done=%b stalls=%0d want 1 3", ok, st);
        end
        n_cmp++;
        if (rd !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL word_load: got %h want deadbeef", rd);
        end
    endtask

    task automatic test_byte_half();
        int st; logic [31:0] rd; logic m; bit ok;
        access(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, st, rd, m, ok);
        n_cmp++;
        if (!ok || rd !== 32'hFFFFFFDE) begin
            n_bad++;
            $display("FAIL lb_sext: got %h want ffffffde", rd);
        end
        access(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, st, rd, m, ok);
        n_cmp++;
        if (!ok || rd !== 32'h000000DE) begin
            n_bad++;
            $display("FAIL lbu: got %h want 000000de", rd);
        end
        access(1'b0, 32'h10, 32'h0, 2'b01, 1'b1, st, rd, m, ok);
        n_cmp++;
        if (!ok || rd !== 32'hFFFFBEEF) begin
            n_bad++;
            $display("FAIL lh_sext: got %h want ffffbeef", rd);
        end
        access(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, st, rd, m, ok);
        n_cmp++;
        if (!ok || rd !== 32'h0000DEAD) begin
            n_bad++;
            $display("FAIL lhu_upper: got %h want 0000dead", rd);
        end
    endtask

    task automatic test_store_byte();
        int st; logic [31:0] rd; logic m; bit ok;
        access(1'b1, 32'h11, 32'hAAAAAA55, 2'b00, 1'b0, st, rd, m, ok);
        n_cmp++;
        if (!ok || rd !== 32'h0000DEAD) begin
            n_bad++;
            $display("FAIL rdata_hold_store: got %h want 0000dead", rd);
        end
        access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, st, rd, m, ok);
        n_cmp++;
        if (!ok || rd !== 32'hDEAD55EF) begin
            n_bad++;
            $display("FAIL sb_merge: got %h want dead55ef", rd);
        end
        access(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, st, rd, m, ok);
        n_cmp++;
        if (!ok || rd !== 32'hDEAD55EF) begin
            n_bad++;
            $display("FAIL width11_as_word: got %h want dead55ef", rd);
        end
    endtask

    task automatic test_misalign();
        int st; logic [31:0] rd; logic m; bit ok;
        access(1'b1, 32'h12, 32'hCAFEF00D, 2'b10, 1'b0, st, rd, m, ok);
`ifdef DMEM_MISALIGN_TRAP_EN
        n_cmp++;
        if (!ok || m !== 1'b1 || st != 3) begin
            n_bad++;
            $display("FAIL mis_store_flag: mis=%b stalls=%0d want 1 3", m, st);
        end
        access(1'b0, 32'h11, 32'h0, 2'b01, 1'b0, st, rd, m, ok);
        n_cmp++;
        if (!ok || m !== 1'b1 || rd !== 32'd0) begin
            n_bad++;
            $display("FAIL mis_load: mis=%b rd=%h want 1 0", m, rd);
        end
        access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, st, rd, m, ok);
        n_cmp++;
        if (!ok || m !== 1'b0 || rd !== 32'hDEAD55EF) begin
            n_bad++;
            $display("FAIL mis_store_suppressed: mis=%b rd=%h want 0 dead55ef", m, rd);
        end
`else
        n_cmp++;
        if (!ok || m !== 1'b0) begin
            n_bad++;
            $display("FAIL align_store_flag: mis=%b want 0", m);
        end
        access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, st, rd, m, ok);
        n_cmp++;
        if (!ok || rd !== 32'hCAFEF00D) begin
            n_bad++;
            $display("FAIL align_store_down: got %h want cafef00d", rd);
        end
        access(1'b0, 32'h11, 32'h0, 2'b01, 1'b0, st, rd, m, ok);
        n_cmp++;
        if (!ok || m !== 1'b0 || rd !== 32'h0000F00D) begin
            n_bad++;
            $display("FAIL align_load_down: mis=%b rd=%h want 0 0000f00d", m, rd);
        end
`endif
    endtask

    task automatic test_reset_abort();
        int st; logic [31:0] rd; logic m; bit ok;
        @(negedge clk_i);
        req_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = 32'h20;
        wdata_i = 32'h12345678;
        width_i = 2'b10;
        @(posedge clk_i);
        #2;
        req_i = 1'b0;
        we_i  = 1'b0;
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if (stall_o !== 1'b0 || done_o !== 1'b0 || rdata_o !== 32'd0) begin
            n_bad++;
            $display("FAIL abort_outputs: stall=%b done=%b rd=%h want 0 0 0",
                     stall_o, done_o, rdata_o);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        access(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, st, rd, m, ok);
        n_cmp++;
        if (!ok || rd !== 32'd0) begin
            n_bad++;
            $display("FAIL abort_no_write: got %h want 0", rd);
        end
    endtask

    task automatic test_wrap();
        int st; logic [31:0] rd; logic m; bit ok;
        access(1'b1, 32'h400, 32'hA5A55A5A, 2'b10, 1'b0, st, rd, m, ok);
        access(1'b0, 32'h000, 32'h0, 2'b10, 1'b0, st, rd, m, ok);
        n_cmp++;
        if (!ok || rd !== 32'hA5A55A5A) begin
            n_bad++;
            $display("FAIL wrap: got %h want a5a55a5a", rd);
        end
    endtask

    task automatic test_back_to_back();
        int first_done;
        int second_done;
        logic done_stall;
        first_done  = -1;
        second_done = -1;
        done_stall  = 1'b1;
        @(negedge clk_i);
        req_i      = 1'b1;
        we_i       = 1'b0;
        addr_i     = 32'h10;
        width_i    = 2'b10;
        sign_ext_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (done_o) begin
                if (first_done < 0) begin
                    first_done = i;
                    done_stall = stall_o;
                end else if (second_done < 0) begin
                    second_done = i;
                end
            end
            @(negedge clk_i);
            if (second_done >= 0) break;
        end
        req_i = 1'b0;
        n_cmp++;
        if (first_done != 3 || second_done != 7) begin
            n_bad++;
            $display("FAIL b2b_timing: done at %0d,%0d want 3,7",
                     first_done, second_done);
        end
        n_cmp++;
        if (done_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_done_nostall: got %b want 0", done_stall);
        end
    endtask

    initial begin
        rst_i      = 1'b0;
        req_i      = 1'b0;
        we_i       = 1'b0;
        addr_i     = 32'd0;
        wdata_i    = 32'd0;
        width_i    = 2'b00;
        sign_ext_i = 1'b0;
        for (int i = 0; i < 256; i++) dut.u_array.memory[i] = 32'd0;
        test_reset();
        test_word();
        test_byte_half();
        test_store_byte();
        test_misalign();
        test_reset_abort();
        test_wrap();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: data-array size in 32-bit words; must be a power of two.
REQ-002 Parameter LATENCY, default 2: BUSY cycles per access; legal range 1..15.
REQ-003 clk_i  input  1  clock, rising-edge active.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  1  MEM-stage access request; held stable by the pipeline while stall_o is high.
REQ-006 we_i  input  1  1 = store, 0 = load.
REQ-007 addr_i  input  32  byte address (ALU result from EX/MEM).
REQ-008 wdata_i  input  32  store data (rs2 value from EX/MEM).
REQ-009 width_i  input  2  access width: 00 byte, 01 half, 10 word; 11 reserved.
REQ-010 sign_ext_i  input  1  load extension: 1 sign-extend, 0 zero-extend.
REQ-011 rdata_o  output  32  load result, extended to 32 bits.
REQ-012 stall_o  output  1  freeze PC, IF/ID, ID/EX and EX/MEM; bubble into MEM/WB.
REQ-013 done_o  output  1  one-cycle pulse: access complete, rdata_o valid.
REQ-014 misalign_o  output  1  one-cycle pulse with done_o when the access was misaligned (macro-dependent, see REQ-030).

Function
REQ-015 FSM states: IDLE, BUSY, DONE.
REQ-016 IDLE with req_i=1 at a rising edge: latch we/addr/wdata/width/sign_ext, load counter with LATENCY-1, go to BUSY.
REQ-017 BUSY: decrement the counter each cycle; when it reaches 0, perform the access at that edge and go to DONE.
REQ-018 DONE: done_o=1, stall_o=0; go to IDLE on the next edge; any req_i present in DONE is ignored, because it is the same instruction leaving MEM.
REQ-019 stall_o = (IDLE and req_i) or BUSY, combinational; a request first seen in cycle N stalls cycles N..N+LATENCY, and DONE falls in cycle N+LATENCY+1.
REQ-020 Word index = latched addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap.
REQ-021 Store byte lanes: byte writes lane addr[1:0]; half writes lanes {addr[1],0}+{0,1}; word writes all four lanes; unwritten lanes are preserved.
REQ-022 Load: extract the same lanes, right-align, then extend per the latched sign_ext.
REQ-023 rdata_o updates only on load completion and holds its value across stores and idle cycles.
REQ-024 width 11 is treated as word.
REQ-025 Back-to-back requests: the earliest second-request acceptance is the IDLE cycle after DONE.

Reset
REQ-026 Reset forces state IDLE, counter 0, rdata_o 0, done_o 0, misalign_o 0 and latched request fields 0; stall_o therefore follows req_i.
REQ-027 Reset asserted mid-access aborts the access; a store in flight shall not modify the array.
REQ-028 The data array is not reset; the bench initialises it hierarchically.

Configuration
REQ-029 Macro DMEM_MISALIGN_TRAP_EN selects misalignment handling.
REQ-030 Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned; the store is suppressed, the load returns 0 with rdata_o updated, and misalign_o pulses with done_o. Timing is unchanged.
REQ-031 Undefined: low address bits below the access width are forced to 0, so the access is aligned down; misalign_o is tied 0.

Structure
REQ-032 Shared package cpu_pkg holds the width encodings (WIDTH_BYTE/HALF/WORD) and the FSM state enum.
REQ-033 Sub-module dmem_array: synchronous-write, asynchronous-read word array with a 4-bit byte enable; register array named memory.

Verification
REQ-034 Write word 0xDEADBEEF @0x10, then load word @0x10 -> rdata_o=0xDEADBEEF; with LATENCY=2, stall_o high for exactly 3 cycles per access.
REQ-035 After REQ-034: load byte @0x13, sign_ext=1 -> 0xFFFFFFDE; sign_ext=0 -> 0x000000DE; load half @0x10, sign_ext=1 -> 0xFFFFBEEF.
REQ-036 Store byte 0x55 @0x11 over 0xDEADBEEF, then load word @0x10 -> 0xDEAD55EF.
REQ-037 Word store @0x12: with the macro, misalign_o=1 and memory is unchanged; without it, the store lands at 0x10.
REQ-038 Pull rst_i low during BUSY of a store of 0x12345678 @0x20 -> word @0x20 unchanged, and stall_o, done_o, rdata_o return to 0 immediately.
REQ-039 Store @0x400 with DEPTH_WORDS=256 -> the word is readable @0x000 (wrap-around).
